// File: rtl/rgb_palette_quantizer_if.sv
// Pixel-in / index-out handshake bundle for rgb_palette_quantizer,
// including the palette write port and the busy flag.
interface rgb_palette_quantizer_if;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [5:0]  out_dist;
  logic        busy;

  modport master (
    output pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_index, out_dist, busy
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_index, out_dist, busy
  );
endinterface

// File: rtl/rgb_palette_quantizer.sv
// Nearest-palette-colour search: maps a 12-bit {r,g,b} pixel to the index of the
// closest of 16 writable palette entries (Manhattan distance), one entry per clock.
module rgb_palette_quantizer (
  input logic               Clk,
  input logic               Reset,
  rgb_palette_quantizer_if.slave bus
);

  localparam int ENTRIES = 16;
  localparam int CW      = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  function automatic logic [5:0] manhattan(input logic [3*CW-1:0] x, input logic [3*CW-1:0] y);
    manhattan = {2'b00, abs_diff(x[3*CW-1:2*CW], y[3*CW-1:2*CW])}
              + {2'b00, abs_diff(x[2*CW-1:CW],   y[2*CW-1:CW])}
              + {2'b00, abs_diff(x[CW-1:0],      y[CW-1:0])};
  endfunction

  logic [3*CW-1:0] pal_r [ENTRIES];
  logic [1:0]      state_r;
  logic [3*CW-1:0] pix_r;
  logic [3:0]      cnt_r;
  logic [5:0]      best_dist_r;
  logic [3:0]      best_idx_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic [3:0]      out_index_r;
  logic [5:0]      out_dist_r;

  logic [5:0]      cur_dist_s;
  logic [5:0]      nxt_dist_s;
  logic [3:0]      nxt_idx_s;

  // Candidate best after comparing entry cnt_r; reads the pre-write palette value.
  always_comb begin
    cur_dist_s = manhattan(pix_r, pal_r[cnt_r]);
    if (cur_dist_s < best_dist_r) begin
      nxt_dist_s = cur_dist_s;
      nxt_idx_s  = cnt_r;
    end else begin
      nxt_dist_s = best_dist_r;
      nxt_idx_s  = best_idx_r;
    end
  end

  // Palette register file; writes are accepted in every state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pal_r[i] <= 12'h000;
      end
    end else if (bus.pal_we) begin
      pal_r[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  // Search sequencer with registered handshake outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      pix_r       <= 12'h000;
      cnt_r       <= 4'd0;
      best_dist_r <= 6'd63;
      best_idx_r  <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_index_r <= 4'd0;
      out_dist_r  <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            pix_r       <= bus.in_rgb;
            cnt_r       <= 4'd0;
            best_dist_r <= 6'd63;
            best_idx_r  <= 4'd0;
            state_r     <= ST_SEARCH;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_SEARCH: begin
          best_dist_r <= nxt_dist_s;
          best_idx_r  <= nxt_idx_s;
          cnt_r       <= cnt_r + 4'd1;
          // Last entry: publish the result including this cycle's comparison.
          if (cnt_r == 4'd15) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            out_index_r <= nxt_idx_s;
            out_dist_r  <= nxt_dist_s;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_index = out_index_r;
  assign bus.out_dist  = out_dist_r;

endmodule
